// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steps FETCH -> LOAD -> DECODE -> EXECUTE, owns the
// program counter and retired count, and parks in HALT or FAULT until reset.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4),
  parameter logic [5:0]            HALT_OPCODE = 6'h3F,
  parameter int                    TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  ir_load,
  output logic                  exec_start,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  fault,
  output logic [15:0]           retired
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    DECODE  = 3'd3,
    EXECUTE = 3'd4,
    HALT    = 3'd5,
    FAULT   = 3'd6
  } state_e;

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [15:0]             retired_q, retired_d;

  logic [5:0] opcode;
  logic       is_halt;
  logic       unused_ir_bits;

  assign opcode  = instruction[DATA_WIDTH-1 -: 6];
  assign is_halt = (opcode == HALT_OPCODE);
  // Only the opcode field matters here; the operand bits belong to the execute stage.
  assign unused_ir_bits = ^instruction[DATA_WIDTH-7:0];

  // NOTE: reset is in the sensitivity list so it acts without a clock edge, and every
  // flop uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // NOTE: every variable gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = LOAD;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      LOAD:   state_d = DECODE;
      DECODE: state_d = is_halt ? HALT : EXECUTE;
      EXECUTE: begin
        // exec_done only counts from EXECUTE, so a done seen during DECODE is ignored.
        if (exec_done) begin
          pc_d      = branch_taken ? branch_target : pc_q + PC_STEP;
          retired_d = retired_q + 16'd1;
          state_d   = FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == FETCH);
    ir_load    = (state_q == LOAD);
    exec_start = (state_q == DECODE) && !is_halt;
    halted     = (state_q == HALT);
    fault      = (state_q == FAULT);
    mem_addr   = pc_q;
    pc         = pc_q;
    state      = state_q;
    retired    = retired_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed vector table, hand-written corner sequences,
// and random traffic compared every cycle against a transaction-level model.
module tb_fetch_sequencer;

  localparam int TIMEOUT = 15;
  localparam int P_IDLE = 0, P_FETCH = 1, P_LOAD = 2, P_DECODE = 3,
                 P_EXEC = 4, P_HALT = 5, P_FAULT = 6;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready, exec_done, branch_taken;
  logic [31:0] instruction, branch_target;
  logic        mem_req, ir_load, exec_start, halted, fault;
  logic [31:0] mem_addr, pc;
  logic [2:0]  state;
  logic [15:0] retired;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
    .instruction(instruction), .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .ir_load(ir_load), .exec_start(exec_start), .pc(pc), .state(state),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_req, obs_ld, obs_es;

  // Reference model: phase code, pc, retired count, consecutive unready FETCH cycles.
  int          m_phase;
  logic [31:0] m_pc;
  logic [15:0] m_ret;
  int          m_unready;

  typedef struct {
    logic        st, mr;
    logic [31:0] ins;
    logic        ed, bt;
    logic [31:0] btg;
    int          e_state;
    logic [31:0] e_pc;
    logic [15:0] e_ret;
    logic        e_req, e_ld, e_es;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_pc = 32'h0; m_ret = 16'h0; m_unready = 0;
  endtask

  task automatic compare_model();
    check("m_state",   64'(state),      64'(m_phase));
    check("m_pc",      64'(pc),         64'(m_pc));
    check("m_addr",    64'(mem_addr),   64'(m_pc));
    check("m_retired", 64'(retired),    64'(m_ret));
    check("m_req",     64'(mem_req),    64'(m_phase == P_FETCH));
    check("m_ld",      64'(ir_load),    64'(m_phase == P_LOAD));
    check("m_es",      64'(exec_start), 64'(m_phase == P_DECODE && instruction[31:26] != 6'h3F));
    check("m_halted",  64'(halted),     64'(m_phase == P_HALT));
    check("m_fault",   64'(fault),      64'(m_phase == P_FAULT));
  endtask

  task automatic model_step();
    case (m_phase)
      P_IDLE: if (start) begin m_phase = P_FETCH; m_unready = 0; end
      P_FETCH: begin
        if (mem_ready) m_phase = P_LOAD;
        else begin
          m_unready++;
          if (m_unready == TIMEOUT) m_phase = P_FAULT;
        end
      end
      P_LOAD:   m_phase = P_DECODE;
      P_DECODE: m_phase = (instruction[31:26] == 6'h3F) ? P_HALT : P_EXEC;
      P_EXEC: begin
        if (exec_done) begin
          m_pc      = branch_taken ? branch_target : m_pc + 32'd4;
          m_ret     = m_ret + 16'd1;
          m_phase   = P_FETCH;
          m_unready = 0;
        end
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic tick(input logic st, input logic mr, input logic [31:0] ins,
                      input logic ed, input logic bt, input logic [31:0] btg);
    @(negedge clk);
    start = st; mem_ready = mr; instruction = ins;
    exec_done = ed; branch_taken = bt; branch_target = btg;
    #1;
    compare_model();
    obs_req += int'(mem_req);
    obs_ld  += int'(ir_load);
    obs_es  += int'(exec_start);
    model_step();
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0; mem_ready = 1'b0; instruction = 32'h0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    #1;
    compare_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // From FETCH with immediate ready and immediate done, one sequential instruction.
  task automatic run_one(input logic [31:0] ins);
    tick(1'b0, 1'b1, ins, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, ins, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, ins, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, ins, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; mem_ready = 1'b0; instruction = 32'h0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    obs_req = 0; obs_ld = 0; obs_es = 0;
    model_reset();

    vecs[0] = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 2, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 3, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 4, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 4, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1, 32'h4, 16'h1, 1'b1, 1'b0, 1'b0};

    // Reset state and idle without start.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_tick();
      check("idle_state", 64'(state), 64'd0);
      check("idle_pc", 64'(pc), 64'd0);
      check("idle_strobes", 64'({mem_req, ir_load, exec_start, halted, fault}), 64'd0);
    end

    // First instruction, table driven.
    obs_ld = 0; obs_es = 0;
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].st, vecs[i].mr, vecs[i].ins, vecs[i].ed, vecs[i].bt, vecs[i].btg);
      check($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      check($sformatf("vec%0d_pc", i), 64'(pc), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d_ret", i), 64'(retired), 64'(vecs[i].e_ret));
      check($sformatf("vec%0d_strobes", i), 64'({mem_req, ir_load, exec_start}),
            64'({vecs[i].e_req, vecs[i].e_ld, vecs[i].e_es}));
    end
    check("first_ir_load_count", 64'(obs_ld), 64'd1);
    check("first_exec_start_count", 64'(obs_es), 64'd1);

    // Wait states: three unready FETCH cycles, then ready.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    obs_req = 0; obs_ld = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("wait_addr", 64'(mem_addr), 64'd0);
    end
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("wait_req_count", 64'(obs_req), 64'd4);
    check("wait_ld_count", 64'(obs_ld), 64'd1);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Taken branch.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);   // DECODE: this done is ignored
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    @(posedge clk); #1;
    check("br_pc", 64'(pc), 64'h100);
    check("br_addr", 64'(mem_addr), 64'h100);
    check("br_retired", 64'(retired), 64'd1);
    check("br_state", 64'(state), 64'd1);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Halt opcode.
    do_reset();
    obs_es = 0;
    tick(1'b1, 1'b0, 32'hFC000000, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'hFC000000, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'hFC000000, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'hFC000000, 1'b0, 1'b0, 32'h0);
    check("halt_no_exec_start", 64'(exec_start), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 32'hFC000000, 1'b1, 1'b1, 32'h40);
      check("halt_state", 64'(state), 64'd5);
      check("halt_flag", 64'(halted), 64'd1);
      check("halt_pc", 64'(pc), 64'd0);
    end
    check("halt_exec_start_count", 64'(obs_es), 64'd0);

    // Fetch timeout.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    obs_req = 0;
    for (int i = 0; i < TIMEOUT; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("to_req_count", 64'(obs_req), 64'd15);
    tick(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    check("to_state", 64'(state), 64'd6);
    check("to_fault", 64'(fault), 64'd1);
    check("to_req", 64'(mem_req), 64'd0);

    // Ready on the last tolerated FETCH cycle.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("late_ready_state", 64'(state), 64'd2);
    check("late_ready_fault", 64'(fault), 64'd0);

    // Asynchronous reset in the middle of EXECUTE.
    do_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_one(32'h0);
    run_one(32'h0);
    tick(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("pre_rst_state", 64'(state), 64'd4);
    check("pre_rst_pc", 64'(pc), 64'd8);
    check("pre_rst_retired", 64'(retired), 64'd2);
    @(negedge clk);
    exec_done = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_state", 64'(state), 64'd0);
    check("arst_pc", 64'(pc), 64'd0);
    check("arst_addr", 64'(mem_addr), 64'd0);
    check("arst_retired", 64'(retired), 64'd0);
    @(posedge clk); #1;
    check("arst_hold_pc", 64'(pc), 64'd0);
    check("arst_hold_retired", 64'(retired), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exec_done = 1'b0;
    idle_tick();

    // Random traffic against the model; the last runs starve memory to reach FAULT.
    for (int run = 0; run < 8; run++) begin
      int ready_pct;
      ready_pct = (run < 6) ? 60 : 5;
      do_reset();
      for (int c = 0; c < 300; c++) begin
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(99) < 5) ins[31:26] = 6'h3F;
        else if (ins[31:26] == 6'h3F) ins[31:26] = 6'h00;
        tick(1'($urandom_range(99) < 30), 1'($urandom_range(99) < ready_pct), ins,
             1'($urandom_range(99) < 40), 1'($urandom_range(99) < 30), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
